menu_select_screen: RTL

//  Parametrised OLED menu layer for game screens. Overlays a cursor highlight band on NUM_OPTS

---
 rtl/menu_select_screen.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/menu_select_screen.sv
// Menu overlay for the OLED pixel stream: draws a cursor highlight band over option rows,
// handles up/down/select navigation, flashes the chosen row, then hands it off via valid/ready.
module menu_select_screen #(
  parameter int unsigned  NUM_OPTS     = 2,
  parameter int unsigned  ROW_Y0       = 35,
  parameter int unsigned  ROW_PITCH    = 9,
  parameter int unsigned  ROW_H        = 5,
  parameter int unsigned  X_MIN        = 20,
  parameter int unsigned  X_MAX        = 70,
  parameter bit           WRAP         = 1'b1,
  parameter int unsigned  FLASH_FRAMES = 8,
  parameter int unsigned  FLASH_CYCLES = 3,
  parameter logic [15:0]  FG           = 16'h0000,
  parameter logic [15:0]  BG           = 16'hFFFF,
  parameter logic [15:0]  HL           = 16'h5FFF,
  localparam int unsigned CW           = (NUM_OPTS > 1) ? $clog2(NUM_OPTS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          frame_begin,
  input  logic [6:0]    x,
  input  logic [5:0]    y,
  input  logic          text_px,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_sel,
  output logic [15:0]   oled_data,
  output logic [CW-1:0] cursor,
  output logic          sel_valid,
  output logic [CW-1:0] sel_idx,
  input  logic          sel_ready
);

  localparam int unsigned FrW       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int unsigned NumPhases = 2 * FLASH_CYCLES;
  localparam int unsigned PhW       = (NumPhases > 1) ? $clog2(NumPhases) : 1;

  localparam logic [CW-1:0]  LastOpt   = CW'(NUM_OPTS - 1);
  localparam logic [FrW-1:0] LastFrame = FrW'(FLASH_FRAMES - 1);
  localparam logic [PhW-1:0] LastPhase = PhW'(NumPhases - 1);
  localparam logic [7:0]     XMin8     = X_MIN[7:0];
  localparam logic [7:0]     XMax8     = X_MAX[7:0];

  typedef enum logic [2:0] {
    StIdle,
    StBrowse,
    StFlash,
    StValid,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cursor_q, cursor_d;
  logic [CW-1:0]   sel_idx_q, sel_idx_d;
  logic [FrW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [PhW-1:0]  phase_cnt_q, phase_cnt_d;
  logic [15:0]     oled_q, oled_d;
  logic [2:0]      btn_lvl_q, btn_lvl_d;
  logic [2:0]      btn_prev_q, btn_prev_d;

  logic [2:0] btn_edge;
  logic       up_edge, down_edge, sel_edge;

  // Level registers reset high so a button already held at reset must be released first.
  always_comb begin
    btn_lvl_d  = {btn_sel, btn_down, btn_up};
    btn_prev_d = btn_lvl_q;
    btn_edge   = btn_lvl_q & ~btn_prev_q;
    up_edge    = btn_edge[0];
    down_edge  = btn_edge[1];
    sel_edge   = btn_edge[2];
  end

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    sel_idx_d   = sel_idx_q;
    frame_cnt_d = frame_cnt_q;
    phase_cnt_d = phase_cnt_q;

    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StBrowse;
          cursor_d = '0;
        end
        StBrowse: begin
          if (sel_edge) begin
            state_d     = StFlash;
            sel_idx_d   = cursor_q;
            frame_cnt_d = '0;
            phase_cnt_d = '0;
          end else if (up_edge && !down_edge) begin
            if (cursor_q == '0) begin
              cursor_d = WRAP ? LastOpt : '0;
            end else begin
              cursor_d = cursor_q - CW'(1);
            end
          end else if (down_edge && !up_edge) begin
            if (cursor_q == LastOpt) begin
              cursor_d = WRAP ? '0 : LastOpt;
            end else begin
              cursor_d = cursor_q + CW'(1);
            end
          end
        end
        StFlash: begin
          if (frame_begin) begin
            if (frame_cnt_q == LastFrame) begin
              frame_cnt_d = '0;
              if (phase_cnt_q == LastPhase) begin
                phase_cnt_d = '0;
                state_d     = StValid;
              end else begin
                phase_cnt_d = phase_cnt_q + PhW'(1);
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FrW'(1);
            end
          end
        end
        StValid: begin
          if (sel_ready) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  logic                hl_en;
  logic [CW-1:0]       hl_row;
  logic [NUM_OPTS-1:0] hl_mask;
  logic [NUM_OPTS-1:0] in_row;
  logic [7:0]          x8, y8;
  logic                in_x;

  always_comb begin
    hl_en  = 1'b0;
    hl_row = '0;
    unique case (state_q)
      StBrowse, StValid, StDone: begin
        hl_en  = 1'b1;
        hl_row = cursor_q;
      end
      StFlash: begin
        // Even phases are "on", so the flash starts lit.
        hl_en  = ~phase_cnt_q[0];
        hl_row = sel_idx_q;
      end
      default: begin
        hl_en  = 1'b0;
        hl_row = '0;
      end
    endcase
    for (int r = 0; r < int'(NUM_OPTS); r++) begin
      hl_mask[r] = hl_en && (hl_row == CW'(r));
    end
  end

  assign x8   = {1'b0, x};
  assign y8   = {2'b00, y};
  assign in_x = (x8 >= XMin8) && (x8 <= XMax8);

  for (genvar r = 0; r < NUM_OPTS; r++) begin : g_row
    localparam int unsigned RowTop   = ROW_Y0 + r * ROW_PITCH;
    localparam int unsigned RowBot   = RowTop + ROW_H - 1;
    localparam logic [7:0]  RowTop8  = RowTop[7:0];
    localparam logic [7:0]  RowBot8  = RowBot[7:0];
    // Bands reaching past the last screen line are suppressed entirely.
    localparam bit          Drawable = (ROW_H > 0) && (RowBot <= 63);
    assign in_row[r] = Drawable && (y8 >= RowTop8) && (y8 <= RowBot8);
  end

  always_comb begin
    oled_d = BG;
    if (text_px) begin
      oled_d = FG;
    end else if (in_x && |(in_row & hl_mask)) begin
      oled_d = HL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cursor_q    <= '0;
      sel_idx_q   <= '0;
      frame_cnt_q <= '0;
      phase_cnt_q <= '0;
      oled_q      <= BG;
      btn_lvl_q   <= '1;
      btn_prev_q  <= '1;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      sel_idx_q   <= sel_idx_d;
      frame_cnt_q <= frame_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      oled_q      <= oled_d;
      btn_lvl_q   <= btn_lvl_d;
      btn_prev_q  <= btn_prev_d;
    end
  end

  assign oled_data = oled_q;
  assign cursor    = cursor_q;
  assign sel_valid = (state_q == StValid);
  assign sel_idx   = sel_idx_q;

endmodule
